// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - 640x480@60 raster timing with frame/animation strobes.
// Optional macro SYNC_DELAY_EN adds one register stage on hs/vs to match pixel pipelines.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int ANIM_DIV = 6
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic       sync,
  output logic       frame_start,
  output logic       anim_tick,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC - 1;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC - 1;

  typedef enum logic {HOLD, RUN} state_t;

  state_t     state;
  logic [9:0] hc_next;
  logic [9:0] vc_next;
  logic       hs_next;
  logic       vs_next;
  logic       blank_next;
  logic       frame_next;
  logic [7:0] anim_cnt;
  logic [7:0] anim_inc;
  logic       hs_r;
  logic       vs_r;

  // HOLD presents (0,0) as the next position so the first frame starts one edge after release.
  always_comb begin
    hc_next = '0;
    vc_next = '0;
    if (state == RUN) begin
      if (DrawX == 10'(H_TOTAL - 1)) begin
        hc_next = '0;
        if (DrawY == 10'(V_TOTAL - 1)) vc_next = '0;
        else                           vc_next = DrawY + 10'd1;
      end else begin
        hc_next = DrawX + 10'd1;
        vc_next = DrawY;
      end
    end
  end

  always_comb begin
    hs_next    = !((hc_next >= 10'(HS_START)) && (hc_next <= 10'(HS_END)));
    vs_next    = !((vc_next >= 10'(VS_START)) && (vc_next <= 10'(VS_END)));
    blank_next = (hc_next < 10'(H_ACTIVE)) && (vc_next < 10'(V_ACTIVE));
    frame_next = (hc_next == 10'd0) && (vc_next == 10'd0);
    anim_inc   = anim_cnt + 8'd1;
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= HOLD;
      DrawX       <= '0;
      DrawY       <= '0;
      hs_r        <= 1'b1;
      vs_r        <= 1'b1;
      blank       <= 1'b0;
      frame_start <= 1'b0;
      anim_tick   <= 1'b0;
      frame_count <= '0;
      anim_cnt    <= '0;
    end else begin
      state       <= RUN;
      DrawX       <= hc_next;
      DrawY       <= vc_next;
      hs_r        <= hs_next;
      vs_r        <= vs_next;
      blank       <= blank_next;
      frame_start <= frame_next;
      if (frame_next) begin
        // The first frame after reset is frame 0, so only RUN-state frame starts count.
        if (state == RUN) frame_count <= frame_count + 8'd1;
        if (anim_inc == 8'(ANIM_DIV)) begin
          anim_tick <= 1'b1;
          anim_cnt  <= '0;
        end else begin
          anim_tick <= 1'b0;
          anim_cnt  <= anim_inc;
        end
      end else begin
        anim_tick <= 1'b0;
      end
    end
  end

`ifdef SYNC_DELAY_EN
  logic hs_d;
  logic vs_d;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_d <= 1'b1;
      vs_d <= 1'b1;
    end else begin
      hs_d <= hs_r;
      vs_d <= vs_r;
    end
  end

  assign hs = hs_d;
  assign vs = vs_d;
`else
  assign hs = hs_r;
  assign vs = vs_r;
`endif

  assign sync = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen on a scaled-down raster.
module tb_vga_timing_gen;

  // Scaled raster: 15 clocks/line, 10 lines/frame, keeps 257 frames short.
  localparam int HA = 8, HF = 2, HSY = 3, HB = 2;
  localparam int VA = 6, VF = 1, VSY = 2, VB = 1;
  localparam int AD = 6;
  localparam int HT = HA + HF + HSY + HB;
  localparam int VT = VA + VF + VSY + VB;
  localparam int FT = HT * VT;
`ifdef SYNC_DELAY_EN
  localparam bit DLY = 1'b1;
`else
  localparam bit DLY = 1'b0;
`endif

  logic       vga_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [9:0] DrawX, DrawY;
  logic       hs, vs, blank, sync, frame_start, anim_tick;
  logic [7:0] frame_count;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .ANIM_DIV(AD)
  ) dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY),
    .hs(hs), .vs(vs), .blank(blank), .sync(sync), .frame_start(frame_start),
    .anim_tick(anim_tick), .frame_count(frame_count)
  );

  always #5 vga_clk = ~vga_clk;

  typedef struct {
    int         t;
    logic [32:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;
  int   t = -1;

  function automatic logic [32:0] pack(int x, int y, bit h, bit v, bit b, bit fs, int fc, bit tk);
    return {10'(x), 10'(y), h, v, b, fs, 8'(fc), tk};
  endfunction

  function automatic logic [32:0] actual();
    return {DrawX, DrawY, hs, vs, blank, frame_start, frame_count, anim_tick};
  endfunction

  function automatic bit hs_at(int tt);
    int x;
    if (tt < 0) return 1'b1;
    x = (tt % FT) % HT;
    return !(x >= HA + HF && x < HA + HF + HSY);
  endfunction

  function automatic bit vs_at(int tt);
    int y;
    if (tt < 0) return 1'b1;
    y = (tt % FT) / HT;
    return !(y >= VA + VF && y < VA + VF + VSY);
  endfunction

  // Reference: everything follows from the cycle index since the first edge after release.
  function automatic logic [32:0] model(int tt);
    int pos, f, x, y, ts;
    pos = tt % FT;
    f   = tt / FT;
    x   = pos % HT;
    y   = pos / HT;
    ts  = DLY ? tt - 1 : tt;
    return pack(x, y, hs_at(ts), vs_at(ts), (x < HA) && (y < VA), pos == 0,
                f % 256, (pos == 0) && ((f + 1) % AD == 0));
  endfunction

  task automatic check(string name, logic [32:0] act, logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0d: got x=%0d y=%0d hs=%b vs=%b blank=%b fs=%b fc=%0d tick=%b, want x=%0d y=%0d hs=%b vs=%b blank=%b fs=%b fc=%0d tick=%b",
               name, t, act[32:23], act[22:13], act[12], act[11], act[10], act[9], act[8:1], act[0],
               exp[32:23], exp[22:13], exp[12], exp[11], exp[10], exp[9], exp[8:1], exp[0]);
    end
  endtask

  task automatic step();
    @(posedge vga_clk);
    t++;
    @(negedge vga_clk);
    check("model", actual(), model(t));
    foreach (tbl[i]) if (tbl[i].t == t) check("table", actual(), tbl[i].exp);
  endtask

  task automatic check_reset_vals(string name);
    check(name, actual(), pack(0, 0, 1, 1, 0, 0, 0, 0));
    checks++;
    if (sync !== 1'b0) begin
      errors++;
      $display("FAIL %s_sync: got %b want 0", name, sync);
    end
  endtask

  initial begin
    int rx, ry, n;
    // t, x, y, hs, vs, blank, frame_start, frame_count, anim_tick
    tbl.push_back('{0,     pack(0, 0, 1, 1, 1, 1, 0, 0)});
    tbl.push_back('{1,     pack(1, 0, 1, 1, 1, 0, 0, 0)});
    tbl.push_back('{7,     pack(7, 0, 1, 1, 1, 0, 0, 0)});
    tbl.push_back('{8,     pack(8, 0, 1, 1, 0, 0, 0, 0)});
    tbl.push_back('{9,     pack(9, 0, 1, 1, 0, 0, 0, 0)});
    tbl.push_back('{10,    pack(10, 0, DLY ? 1 : 0, 1, 0, 0, 0, 0)});
    tbl.push_back('{11,    pack(11, 0, 0, 1, 0, 0, 0, 0)});
    tbl.push_back('{13,    pack(13, 0, DLY ? 0 : 1, 1, 0, 0, 0, 0)});
    tbl.push_back('{14,    pack(14, 0, 1, 1, 0, 0, 0, 0)});
    tbl.push_back('{15,    pack(0, 1, 1, 1, 1, 0, 0, 0)});
    tbl.push_back('{90,    pack(0, 6, 1, 1, 0, 0, 0, 0)});
    tbl.push_back('{105,   pack(0, 7, 1, DLY ? 1 : 0, 0, 0, 0, 0)});
    tbl.push_back('{106,   pack(1, 7, 1, 0, 0, 0, 0, 0)});
    tbl.push_back('{134,   pack(14, 8, 1, 0, 0, 0, 0, 0)});
    tbl.push_back('{135,   pack(0, 9, 1, DLY ? 0 : 1, 0, 0, 0, 0)});
    tbl.push_back('{136,   pack(1, 9, 1, 1, 0, 0, 0, 0)});
    tbl.push_back('{149,   pack(14, 9, 1, 1, 0, 0, 0, 0)});
    tbl.push_back('{150,   pack(0, 0, 1, 1, 1, 1, 1, 0)});
    tbl.push_back('{750,   pack(0, 0, 1, 1, 1, 1, 5, 1)});
    tbl.push_back('{1650,  pack(0, 0, 1, 1, 1, 1, 11, 1)});
    tbl.push_back('{38399, pack(14, 9, 1, 1, 0, 0, 255, 0)});
    tbl.push_back('{38400, pack(0, 0, 1, 1, 1, 1, 0, 0)});

    repeat (5) begin
      @(negedge vga_clk);
      check_reset_vals("reset_hold");
    end
    reset_n = 1'b1;
    repeat (257 * FT + 20) step();

    for (int k = 0; k < 2; k++) begin
      rx = $urandom_range(HT - 1);
      ry = $urandom_range(VT - 1);
      n  = 0;
      while (!(DrawX == 10'(rx) && DrawY == 10'(ry)) && n <= FT) begin
        step();
        n++;
      end
      checks++;
      if (n > FT) begin
        errors++;
        $display("FAIL midreset_seek: position (%0d,%0d) not reached, got (%0d,%0d)", rx, ry, DrawX, DrawY);
      end
      #2 reset_n = 1'b0;
      #1 check_reset_vals("midreset_async");
      repeat (3) begin
        @(negedge vga_clk);
        check_reset_vals("midreset_hold");
      end
      reset_n = 1'b1;
      t = -1;
      repeat (AD * FT + 30) step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
